// File: rtl/axil_cmd_master.sv
// AXI-Lite initiator: turns one command into one AXI-Lite read or write and
// returns exactly one response, aborting with rsp_resp=2'b11 on timeout.
module axil_cmd_master #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter logic [2:0]  PROT           = 3'b000
) (
  input  logic        axilClk,
  input  logic        axilRst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_write,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_resp,
  output logic        rsp_timeout,
  output logic        busy,
  output logic [31:0] axilReadMaster_araddr,
  output logic [2:0]  axilReadMaster_arprot,
  output logic        axilReadMaster_arvalid,
  output logic        axilReadMaster_rready,
  input  logic        axilReadSlave_arready,
  input  logic [31:0] axilReadSlave_rdata,
  input  logic [1:0]  axilReadSlave_rresp,
  input  logic        axilReadSlave_rvalid,
  output logic [31:0] axilWriteMaster_awaddr,
  output logic [2:0]  axilWriteMaster_awprot,
  output logic        axilWriteMaster_awvalid,
  output logic [31:0] axilWriteMaster_wdata,
  output logic [3:0]  axilWriteMaster_wstrb,
  output logic        axilWriteMaster_wvalid,
  output logic        axilWriteMaster_bready,
  input  logic        axilWriteSlave_awready,
  input  logic        axilWriteSlave_wready,
  input  logic [1:0]  axilWriteSlave_bresp,
  input  logic        axilWriteSlave_bvalid
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4,
    RESP    = 3'd5
  } state_t;

  localparam logic [15:0] TIMEOUT_C = TIMEOUT_CYCLES[15:0];

  state_t      state_r;
  logic [15:0] cnt_r;
  logic        aw_done_r;
  logic        w_done_r;

  logic [15:0] cnt_next_s;
  logic        expire_s;
  logic        active_s;
  logic        advance_s;
  logic        abort_s;
  logic        aw_fire_s;
  logic        w_fire_s;
  logic        aw_now_s;
  logic        w_now_s;

  // Per-cycle decode: handshakes, phase completion and timeout expiry.
  always_comb begin
    cnt_next_s = cnt_r + 16'd1;
    // >= rather than == so a handshake that wins the expiry cycle cannot
    // carry the counter past the limit and disarm the abort
    if (TIMEOUT_C != 16'd0) begin
      expire_s = (cnt_next_s >= TIMEOUT_C);
    end else begin
      expire_s = 1'b0;
    end
    aw_fire_s = axilWriteMaster_awvalid & axilWriteSlave_awready;
    w_fire_s  = axilWriteMaster_wvalid & axilWriteSlave_wready;
    aw_now_s  = aw_done_r | aw_fire_s;
    w_now_s   = w_done_r | w_fire_s;
    case (state_r)
      WR_REQ:  begin active_s = 1'b1; advance_s = aw_now_s & w_now_s; end
      WR_RESP: begin active_s = 1'b1; advance_s = axilWriteSlave_bvalid & axilWriteMaster_bready; end
      RD_REQ:  begin active_s = 1'b1; advance_s = axilReadMaster_arvalid & axilReadSlave_arready; end
      RD_DATA: begin active_s = 1'b1; advance_s = axilReadSlave_rvalid & axilReadMaster_rready; end
      default: begin active_s = 1'b0; advance_s = 1'b0; end
    endcase
    abort_s = active_s & expire_s & ~advance_s;
  end

  // Command FSM; every output is a register updated only here.
  always_ff @(posedge axilClk) begin
    if (axilRst) begin
      state_r                 <= IDLE;
      cnt_r                   <= 16'd0;
      aw_done_r               <= 1'b0;
      w_done_r                <= 1'b0;
      cmd_ready               <= 1'b0;
      rsp_valid               <= 1'b0;
      rsp_write               <= 1'b0;
      rsp_rdata               <= 32'd0;
      rsp_resp                <= 2'b00;
      rsp_timeout             <= 1'b0;
      busy                    <= 1'b0;
      axilReadMaster_araddr   <= 32'd0;
      axilReadMaster_arprot   <= 3'b000;
      axilReadMaster_arvalid  <= 1'b0;
      axilReadMaster_rready   <= 1'b0;
      axilWriteMaster_awaddr  <= 32'd0;
      axilWriteMaster_awprot  <= 3'b000;
      axilWriteMaster_awvalid <= 1'b0;
      axilWriteMaster_wdata   <= 32'd0;
      axilWriteMaster_wstrb   <= 4'd0;
      axilWriteMaster_wvalid  <= 1'b0;
      axilWriteMaster_bready  <= 1'b0;
    end else begin
      axilReadMaster_arprot  <= PROT;
      axilWriteMaster_awprot <= PROT;
      if (active_s) begin
        cnt_r <= cnt_next_s;
      end
      if (abort_s) begin
        axilReadMaster_arvalid  <= 1'b0;
        axilReadMaster_rready   <= 1'b0;
        axilWriteMaster_awvalid <= 1'b0;
        axilWriteMaster_wvalid  <= 1'b0;
        axilWriteMaster_bready  <= 1'b0;
        rsp_rdata               <= 32'd0;
        rsp_resp                <= 2'b11;
        rsp_timeout             <= 1'b1;
        rsp_valid               <= 1'b1;
        state_r                 <= RESP;
      end else begin
        case (state_r)
          IDLE: begin
            if (cmd_valid && cmd_ready) begin
              cmd_ready              <= 1'b0;
              busy                   <= 1'b1;
              cnt_r                  <= 16'd0;
              rsp_write              <= cmd_write;
              axilReadMaster_araddr  <= cmd_addr;
              axilWriteMaster_awaddr <= cmd_addr;
              axilWriteMaster_wdata  <= cmd_wdata;
              axilWriteMaster_wstrb  <= cmd_wstrb;
              if (cmd_write) begin
                axilWriteMaster_awvalid <= 1'b1;
                axilWriteMaster_wvalid  <= 1'b1;
                aw_done_r               <= 1'b0;
                w_done_r                <= 1'b0;
                state_r                 <= WR_REQ;
              end else begin
                axilReadMaster_arvalid <= 1'b1;
                state_r                <= RD_REQ;
              end
            end else begin
              cmd_ready <= 1'b1;
            end
          end
          WR_REQ: begin
            if (aw_now_s && w_now_s) begin
              axilWriteMaster_awvalid <= 1'b0;
              axilWriteMaster_wvalid  <= 1'b0;
              axilWriteMaster_bready  <= 1'b1;
              state_r                 <= WR_RESP;
            end else begin
              if (aw_fire_s) begin
                axilWriteMaster_awvalid <= 1'b0;
                aw_done_r               <= 1'b1;
              end
              if (w_fire_s) begin
                axilWriteMaster_wvalid <= 1'b0;
                w_done_r               <= 1'b1;
              end
            end
          end
          WR_RESP: begin
            if (advance_s) begin
              axilWriteMaster_bready <= 1'b0;
              rsp_resp               <= axilWriteSlave_bresp;
              rsp_rdata              <= 32'd0;
              rsp_timeout            <= 1'b0;
              rsp_valid              <= 1'b1;
              state_r                <= RESP;
            end
          end
          RD_REQ: begin
            if (advance_s) begin
              axilReadMaster_arvalid <= 1'b0;
              axilReadMaster_rready  <= 1'b1;
              state_r                <= RD_DATA;
            end
          end
          RD_DATA: begin
            if (advance_s) begin
              axilReadMaster_rready <= 1'b0;
              rsp_rdata             <= axilReadSlave_rdata;
              rsp_resp              <= axilReadSlave_rresp;
              rsp_timeout           <= 1'b0;
              rsp_valid             <= 1'b1;
              state_r               <= RESP;
            end
          end
          RESP: begin
            if (rsp_ready) begin
              rsp_valid <= 1'b0;
              busy      <= 1'b0;
              cmd_ready <= 1'b1;
              state_r   <= IDLE;
            end
          end
          default: begin
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axil_cmd_master.sv
// Randomized bench for axil_cmd_master: a latency-driven slave plus a
// transaction-level model of the expected response and handshake windows.
module tb_axil_cmd_master;

  localparam int         TO     = 16;
  localparam logic [2:0] PROT_C = 3'b101;
  localparam int         NEVER  = 1000;

  logic        axilClk = 1'b0;
  logic        axilRst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write, rsp_timeout, busy;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [2:0]  arprot, awprot;
  logic        arvalid, rready, arready, rvalid, awvalid, wvalid, bready;
  logic        awready, wready, bvalid;
  logic [1:0]  rresp, bresp;
  logic [3:0]  wstrb;

  int checks = 0;
  int passed = 0;

  typedef struct {
    bit          to;
    int          end_c;
    logic [31:0] rdata;
    logic [1:0]  resp;
  } exp_t;

  axil_cmd_master #(.TIMEOUT_CYCLES(TO), .PROT(PROT_C)) dut (
    .axilClk(axilClk), .axilRst(axilRst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .busy(busy),
    .axilReadMaster_araddr(araddr), .axilReadMaster_arprot(arprot),
    .axilReadMaster_arvalid(arvalid), .axilReadMaster_rready(rready),
    .axilReadSlave_arready(arready), .axilReadSlave_rdata(rdata),
    .axilReadSlave_rresp(rresp), .axilReadSlave_rvalid(rvalid),
    .axilWriteMaster_awaddr(awaddr), .axilWriteMaster_awprot(awprot),
    .axilWriteMaster_awvalid(awvalid), .axilWriteMaster_wdata(wdata),
    .axilWriteMaster_wstrb(wstrb), .axilWriteMaster_wvalid(wvalid),
    .axilWriteMaster_bready(bready), .axilWriteSlave_awready(awready),
    .axilWriteSlave_wready(wready), .axilWriteSlave_bresp(bresp),
    .axilWriteSlave_bvalid(bvalid)
  );

  always #5 axilClk = ~axilClk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Transaction-level expectation: completion cycle counted from acceptance,
  // aborted if the slave has not finished by cycle TO.
  function automatic exp_t model(bit wr, int a_lat, int w_lat, int d_lat,
                                 logic [31:0] sd, logic [1:0] sr);
    exp_t e;
    int   done;
    done    = (wr ? ((a_lat > w_lat) ? a_lat : w_lat) : a_lat) + d_lat;
    e.to    = (done > TO);
    e.end_c = e.to ? TO : done;
    e.rdata = (e.to || wr) ? 32'd0 : sd;
    e.resp  = e.to ? 2'b11 : sr;
    return e;
  endfunction

  task automatic clear_slave();
    arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
  endtask

  task automatic test_txn(input string name, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] strb,
                          input int a_lat, input int w_lat, input int d_lat,
                          input logic [31:0] sd, input logic [1:0] sr, input int hold);
    exp_t         e;
    int           both, n;
    logic [7:0]   got_v, exp_v;
    logic [70:0]  got_a, exp_a;
    logic [43:0]  got_r, exp_r;
    e    = model(wr, a_lat, w_lat, d_lat, sd, sr);
    both = wr ? ((a_lat > w_lat) ? a_lat : w_lat) : a_lat;
    @(negedge axilClk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = strb;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(negedge axilClk);
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) $display("FAIL %s accept: cmd_ready=%b want 1", name, cmd_ready);
    else passed++;
    for (int c = 1; c <= e.end_c; c++) begin
      @(negedge axilClk);
      if (c == 1) cmd_valid = 1'b0;
      exp_v = {wr && (c <= a_lat), wr && (c <= w_lat), wr && (c > both),
               !wr && (c <= a_lat), !wr && (c > a_lat), 1'b1, 1'b0, 1'b0};
      got_v = {awvalid, wvalid, bready, arvalid, rready, busy, cmd_ready, rsp_valid};
      checks++;
      if (got_v !== exp_v)
        $display("FAIL %s handshake c=%0d: aw,w,b,ar,r,busy,cmdr,rspv got %b want %b",
                 name, c, got_v, exp_v);
      else passed++;
      if (wr) begin
        got_a = {awaddr, wdata, wstrb, awprot};
        exp_a = {addr, wd, strb, PROT_C};
      end else begin
        got_a = {araddr, 32'd0, 4'd0, arprot};
        exp_a = {addr, 32'd0, 4'd0, PROT_C};
      end
      checks++;
      if (got_a !== exp_a)
        $display("FAIL %s addr c=%0d: got %h want %h", name, c, got_a, exp_a);
      else passed++;
      arready = !wr && (c == a_lat);
      awready = wr && (c == a_lat);
      wready  = wr && (c == w_lat);
      rvalid  = !wr && (c == both + d_lat);
      bvalid  = wr && (c == both + d_lat);
      rdata   = rvalid ? sd : 32'($urandom);
      rresp   = sr;
      bresp   = sr;
    end
    @(negedge axilClk);
    clear_slave();
    for (int k = 0; k <= hold; k++) begin
      got_r = {rsp_valid, rsp_write, rsp_timeout, rsp_resp, rsp_rdata, cmd_ready, busy,
               arvalid, rready, awvalid, wvalid, bready};
      exp_r = {1'b1, wr, e.to, e.resp, e.rdata, 1'b0, 1'b1, 5'b00000};
      checks++;
      if (got_r !== exp_r)
        $display("FAIL %s response k=%0d: got %h want %h", name, k, got_r, exp_r);
      else passed++;
      rsp_ready = (k == hold);
      @(negedge axilClk);
    end
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, cmd_ready, busy} !== 3'b010)
      $display("FAIL %s release: rspv,cmdr,busy got %b want 010", name,
               {rsp_valid, cmd_ready, busy});
    else passed++;
  endtask

  task automatic test_reset();
    logic [149:0] outs;
    axilRst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'd0;
    cmd_wdata = 32'd0; cmd_wstrb = 4'd0; rsp_ready = 1'b0; rdata = 32'd0;
    rresp = 2'b00; bresp = 2'b00;
    clear_slave();
    repeat (3) @(negedge axilClk);
    outs = {cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp, rsp_timeout, busy,
            araddr, arprot, arvalid, rready, awaddr, awprot, awvalid, wdata, wstrb,
            wvalid, bready};
    checks++;
    if (outs !== 150'd0) $display("FAIL reset outputs: got %h want 0", outs);
    else passed++;
    axilRst = 1'b0;
    @(negedge axilClk);
    checks++;
    if ({cmd_ready, busy, rsp_valid, arprot, awprot} !== {3'b100, PROT_C, PROT_C})
      $display("FAIL reset release: cmdr,busy,rspv,arprot,awprot got %b want %b",
               {cmd_ready, busy, rsp_valid, arprot, awprot}, {3'b100, PROT_C, PROT_C});
    else passed++;
  endtask

  task automatic test_read_zero_wait();
    test_txn("read_zero_wait", 1'b0, 32'h0000_0104, 32'd0, 4'd0, 1, 1, 1,
             32'hDEAD_BEEF, 2'b00, 0);
  endtask

  task automatic test_write_split();
    test_txn("write_split", 1'b1, 32'h0000_2010, 32'h1234_5678, 4'hF, 4, 1, 1,
             32'd0, 2'b10, 0);
    test_txn("write_split_aw_first", 1'b1, 32'h0000_2014, 32'hCAFE_0001, 4'h3, 1, 3, 2,
             32'd0, 2'b00, 0);
  endtask

  task automatic test_backpressure();
    test_txn("backpressure", 1'b0, 32'h0000_0200, 32'd0, 4'd0, 2, 1, 2,
             32'h0BAD_F00D, 2'b01, 5);
  endtask

  task automatic test_timeout();
    test_txn("timeout_ar", 1'b0, 32'h0000_0300, 32'd0, 4'd0, NEVER, 1, 1,
             32'h5555_AAAA, 2'b00, 1);
    test_txn("after_timeout", 1'b0, 32'h0000_0304, 32'd0, 4'd0, 1, 1, 1,
             32'h0102_0304, 2'b00, 0);
    test_txn("timeout_b", 1'b1, 32'h0000_0308, 32'hFFFF_0000, 4'hC, 2, 1, NEVER,
             32'd0, 2'b00, 0);
  endtask

  task automatic test_timeout_coincide();
    test_txn("timeout_coincide", 1'b0, 32'h0000_0400, 32'd0, 4'd0, 3, 1, TO - 3,
             32'h7777_1234, 2'b00, 0);
  endtask

  task automatic test_reset_mid_write();
    logic [149:0] outs;
    @(negedge axilClk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0500;
    cmd_wdata = 32'hA5A5_A5A5; cmd_wstrb = 4'hF;
    @(negedge axilClk);
    cmd_valid = 1'b0; awready = 1'b1; wready = 1'b1;
    @(negedge axilClk);
    awready = 1'b0; wready = 1'b0;
    checks++;
    if (bready !== 1'b1) $display("FAIL reset_mid_write pre: bready=%b want 1", bready);
    else passed++;
    axilRst = 1'b1;
    @(negedge axilClk);
    outs = {cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp, rsp_timeout, busy,
            araddr, arprot, arvalid, rready, awaddr, awprot, awvalid, wdata, wstrb,
            wvalid, bready};
    checks++;
    if (outs !== 150'd0) $display("FAIL reset_mid_write outputs: got %h want 0", outs);
    else passed++;
    axilRst = 1'b0; bvalid = 1'b1; bresp = 2'b00;
    @(negedge axilClk);
    bvalid = 1'b0;
    checks++;
    if ({cmd_ready, rsp_valid, bready, busy} !== 4'b1000)
      $display("FAIL reset_mid_write release: cmdr,rspv,bready,busy got %b want 1000",
               {cmd_ready, rsp_valid, bready, busy});
    else passed++;
    @(negedge axilClk);
    checks++;
    if (rsp_valid !== 1'b0) $display("FAIL reset_mid_write norsp: rsp_valid=%b want 0", rsp_valid);
    else passed++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 14; i++) begin
      bit wr;
      int d;
      wr = 1'($urandom_range(0, 1));
      d  = ($urandom_range(0, 5) == 0) ? NEVER : int'($urandom_range(1, 4));
      test_txn("random", wr, 32'($urandom) & 32'hFFFF_FFFC, 32'($urandom),
               4'($urandom_range(0, 15)), int'($urandom_range(1, 4)),
               int'($urandom_range(1, 4)), d, 32'($urandom),
               2'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_split();
    test_backpressure();
    test_timeout();
    test_timeout_coincide();
    test_reset_mid_write();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
